// File: rtl/wave_gen_param.sv
// rtl/wave_gen_param.sv - phase-accumulator waveform generator; WAVE_GEN_SINE_EN adds a quarter-wave sine ROM
module wave_gen_param #(
    parameter int W     = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [ACC_W-1:0] step,
    input  logic [1:0]       amp_shift,
    output logic [W-1:0]     out_amp,
    output logic             sync
);

    localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

`ifdef WAVE_GEN_SINE_EN
    // Integer Bhaskara sine sampled at bin centres; the peak entry rounds to full half-scale.
    function automatic logic [64*W-1:0] build_rom();
        logic [64*W-1:0] r;
        longint t, u, den, amp;
        r   = '0;
        amp = (longint'(1) << (W-1)) - 1;
        for (int i = 0; i < 64; i++) begin
            t   = 2 * i + 1;
            u   = t * (256 - t);
            den = 81920 - u;
            r[i*W +: W] = W'((amp * 4 * u + den / 2) / den);
        end
        return r;
    endfunction

    localparam logic [64*W-1:0] SINE_ROM = build_rom();

    logic [1:0]   quad;
    logic [5:0]   idx;
    logic [5:0]   ridx;
    logic [W-1:0] sine;
`endif

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [2:0]       act_mode_q, act_mode_d;
    logic [1:0]       act_shift_q, act_shift_d;
    logic [W-1:0]     out_amp_q, out_amp_d;
    logic             sync_q, sync_d;
    logic             carry, wrap;
    logic [W-1:0]     p, wave;

    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, step};
        wrap  = en & carry;
        acc_d = en ? acc_sum : acc_q;
        p     = acc_d[ACC_W-1 -: W];

        // Settings only change at a period boundary or while paused, so a period is never mixed.
        act_mode_d  = (wrap || !en) ? mode      : act_mode_q;
        act_shift_d = (wrap || !en) ? amp_shift : act_shift_q;

`ifdef WAVE_GEN_SINE_EN
        quad = p[W-1 -: 2];
        idx  = 6'({p, 6'b0} >> (W - 2));
        ridx = quad[0] ? ~idx : idx;
        sine = MID | SINE_ROM[int'(ridx)*W +: W];
        if (quad[1]) begin
            sine = ~sine;
        end
`endif

        case (act_mode_d)
            3'd0:    wave = p;
            3'd1:    wave = ~p;
            3'd2:    wave = p[W-1] ? ~{p[W-2:0], 1'b0} : {p[W-2:0], 1'b0};
            3'd3:    wave = p[W-1] ? '0 : '1;
`ifdef WAVE_GEN_SINE_EN
            3'd4:    wave = sine;
`else
            3'd4:    wave = MID;
`endif
            3'd5:    wave = MID;
            default: wave = '0;
        endcase

        out_amp_d = en ? (wave >> act_shift_d) : out_amp_q;
        sync_d    = wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            act_mode_q  <= '0;
            act_shift_q <= '0;
            out_amp_q   <= '0;
            sync_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            act_mode_q  <= act_mode_d;
            act_shift_q <= act_shift_d;
            out_amp_q   <= out_amp_d;
            sync_q      <= sync_d;
        end
    end

    assign out_amp = out_amp_q;
    assign sync    = sync_q;

endmodule

// File: tb/tb_wave_gen_param.sv
// tb/tb_wave_gen_param.sv - randomized self-checking bench for wave_gen_param (W=8, ACC_W=16)
module tb_wave_gen_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] step = 16'd0;
    logic [1:0]  amp_shift = 2'd0;
    logic [7:0]  out_amp;
    logic        sync;

    int checks = 0;
    int errors = 0;

    int m_acc = 0, m_mode = 0, m_shift = 0, m_out = 0, m_sync = 0;

    wave_gen_param #(.W(8), .ACC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .amp_shift (amp_shift),
        .out_amp   (out_amp),
        .sync      (sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wave(input int m, input int p);
        case (m)
            0:       return p;
            1:       return 255 - p;
            2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            3:       return (p < 128) ? 255 : 0;
            4:       return 128;
            5:       return 128;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_acc = 0; m_mode = 0; m_shift = 0; m_out = 0; m_sync = 0;
    endtask

    task automatic model_step();
        int sum;
        if (!rst) begin
            model_reset();
        end else if (en) begin
            sum    = m_acc + int'(step);
            m_sync = (sum >= 65536) ? 1 : 0;
            m_acc  = sum % 65536;
            if (m_sync == 1) begin
                m_mode  = int'(mode);
                m_shift = int'(amp_shift);
            end
            m_out = wave(m_mode, m_acc / 256) >> m_shift;
        end else begin
            m_mode  = int'(mode);
            m_shift = int'(amp_shift);
            m_sync  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
`ifdef WAVE_GEN_SINE_EN
        if (m_mode == 4 && rst) begin
            if (m_acc / 256 == 64)  check("sine_peak", int'(out_amp), 255);
            if (m_acc / 256 == 192) check("sine_trough_le1", int'(out_amp <= 8'd1), 1);
            check("sync", int'(sync), m_sync);
            return;
        end
`endif
        check("out_amp", int'(out_amp), m_out);
        check("sync", int'(sync), m_sync);
    endtask

    initial begin
        int cnt;

        #12;
        check("reset_out_amp", int'(out_amp), 0);
        check("reset_sync", int'(sync), 0);

        // rising saw, one step of phase per clock
        @(negedge clk);
        rst = 1'b1; mode = 3'd0; step = 16'd256; en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (i == 0) check("saw_first", int'(out_amp), 1);
            if (sync) begin
                cnt++;
                check("saw_sync_on_zero", int'(out_amp), 0);
            end
        end
        check("saw_sync_count", cnt, 2);

        // square at full and quarter amplitude
        mode = 3'd3; step = 16'd512;
        for (int i = 0; i < 127; i++) tick();
        cnt = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (out_amp == 8'd255) cnt++;
        end
        check("square_high_count", cnt, 64);
        amp_shift = 2'd2;
        cnt = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (out_amp == 8'd63) cnt++;
        end
        check("square_shift2_high_count", cnt, 64);

        // mode switch mid-period takes effect only at the next wrap
        mode = 3'd0; step = 16'd256; amp_shift = 2'd0;
        for (int i = 0; i < 600 && !(m_mode == 0 && m_shift == 0 && m_acc / 256 == 100); i++) tick();
        check("saw_at_phase_100", int'(out_amp), 100);
        mode = 3'd2;
        for (int i = 0; i < 300; i++) tick();

        // pause and resume
        en = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        en = 1'b1;
        for (int i = 0; i < 50; i++) tick();

        // zero step never wraps
        step = 16'd0;
        for (int i = 0; i < 10; i++) tick();

        // sine mode
        step = 16'd256; mode = 3'd4;
        for (int i = 0; i < 520; i++) begin
            tick();
`ifndef WAVE_GEN_SINE_EN
            if (i == 519) check("sine_disabled_dc", int'(out_amp), 128);
`endif
        end
        mode = 3'd0;
        for (int i = 0; i < 300; i++) tick();

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
`ifdef WAVE_GEN_SINE_EN
                mode = 3'($urandom_range(0, 6));
                if (mode >= 3'd4) mode = mode + 3'd1;
`else
                mode = 3'($urandom_range(0, 7));
`endif
                amp_shift = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       step = 16'd0;
                    1:       step = 16'($urandom_range(1, 1024));
                    default: step = 16'($urandom);
                endcase
            end
            tick();
        end

        // asynchronous reset mid-run
        en = 1'b0; mode = 3'd5; amp_shift = 2'd0;
        tick();
        en = 1'b1; step = 16'd300;
        for (int i = 0; i < 3; i++) tick();
        check("pre_reset_dc", int'(out_amp), 128);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_out_amp", int'(out_amp), 0);
        check("async_reset_sync", int'(sync), 0);
        model_reset();
        tick();
        rst = 1'b1; mode = 3'd0; step = 16'd1000; en = 1'b1;
        tick();
        check("post_reset_first_sample", int'(out_amp), 3);
        for (int i = 0; i < 100; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
